// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared constants, FSM state type and trellis predecessor function for the 4-state Viterbi decoder
package viterbi_pkg;
  localparam int NSTATES = 4;
  localparam int SYM_W = 3;
  localparam int PATH_W = 12;
  typedef enum logic [1:0] {FILL, RUN, DRAIN} surv_state_t;
  function automatic logic [1:0] pred(input logic [1:0] s, input logic d);
    return s == 2'd0 ? (d ? 2'd2 : 2'd0) :
           s == 2'd1 ? (d ? 2'd0 : 2'd2) :
           s == 2'd2 ? (d ? 2'd3 : 2'd1) :
                       (d ? 2'd1 : 2'd3);
  endfunction
endpackage

// File: rtl/surv_row.sv
// surv_row: one register-exchange survivor row of DEPTH symbols, reloaded from its predecessor row
//  clk, reset (sync, active-low), clr (sync clear), load (exchange step),
//  sym (newest symbol), src (predecessor row), row (this row, entry k at [k*SYM_W +: SYM_W])
module surv_row
  import viterbi_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   load,
  input  logic [SYM_W-1:0]       sym,
  input  logic [DEPTH*SYM_W-1:0] src,
  output logic [DEPTH*SYM_W-1:0] row
);
  always_ff @(posedge clk)
    if (!reset || clr) row <= '0;
    else if (load) row <= {src[(DEPTH-1)*SYM_W-1:0], sym};
endmodule

// File: rtl/survivor_exchange.sv
// survivor_exchange: register-exchange survivor memory of the 4-state Viterbi decoder with flush drain
//  clk, reset (sync, active-low); in_valid/in_ready handshake carrying path0 (per-state symbols),
//  acs (per-state decisions), best_state; flush starts a drain; out_valid/out_sym decoded stream;
//  busy high while draining. Macro SURV_BEST_STATE_EN selects the output row by best_state (else row 0).
module survivor_exchange
  import viterbi_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PATH_W-1:0] path0,
  input  logic [3:0]        acs,
  input  logic [1:0]        best_state,
  input  logic              flush,
  output logic              out_valid,
  output logic [SYM_W-1:0]  out_sym,
  output logic              busy
);
  surv_state_t state, state_nxt;
  logic [1:0] sel;
  logic accept, clr;
  logic [CNT_W-1:0] held, held_acc, drain_cnt;
  logic [DEPTH*SYM_W-1:0] rows [NSTATES];
  logic [SYM_W-1:0] syms [NSTATES];
  logic [DEPTH*SYM_W-1:0] drain_reg, sel_post;
`ifdef SURV_BEST_STATE_EN
  assign sel = best_state;
`else
  logic unused_best;
  assign sel = 2'd0;
  assign unused_best = ^best_state;
`endif
  assign in_ready = state != DRAIN;
  assign busy = state == DRAIN;
  assign accept = in_valid && in_ready;
  assign held_acc = accept && held != CNT_W'(DEPTH) ? held + 1'b1 : held;
  assign clr = state == DRAIN && drain_cnt == CNT_W'(1);
  // row[sel] as it will look after this cycle's exchange, captured into the drain register
  assign sel_post = accept ? {rows[pred(sel, acs[sel])][(DEPTH-1)*SYM_W-1:0], syms[sel]} : rows[sel];
  for (genvar s = 0; s < NSTATES; s++) begin : g_row
    assign syms[s] = path0[PATH_W-1-SYM_W*s -: SYM_W];
    surv_row #(.DEPTH(DEPTH)) u_row (
      .clk  (clk),
      .reset(reset),
      .clr  (clr),
      .load (accept),
      .sym  (syms[s]),
      .src  (rows[pred(2'(s), acs[s])]),
      .row  (rows[s])
    );
  end
  always_comb begin
    state_nxt = state;
    if (state == DRAIN) state_nxt = drain_cnt == CNT_W'(1) ? FILL : DRAIN;
    else if (flush && held_acc != '0) state_nxt = DRAIN;
    else if (held_acc == CNT_W'(DEPTH)) state_nxt = RUN;
  end
  always_ff @(posedge clk)
    if (!reset) state <= FILL;
    else state <= state_nxt;
  always_ff @(posedge clk) begin
    if (!reset) begin
      held <= '0;
      drain_cnt <= '0;
      drain_reg <= '0;
      out_valid <= 1'b0;
      out_sym <= '0;
    end else begin
      out_valid <= 1'b0;
      if (state == DRAIN) begin
        out_valid <= 1'b1;
        out_sym <= drain_reg[(drain_cnt - 1'b1)*SYM_W +: SYM_W];
        drain_cnt <= drain_cnt - 1'b1;
        if (drain_cnt == CNT_W'(1)) held <= '0;
      end else begin
        held <= held_acc;
        if (accept && state == RUN) begin
          out_valid <= 1'b1;
          out_sym <= rows[sel][(DEPTH-1)*SYM_W +: SYM_W];
        end
        if (flush && held_acc != '0) begin
          drain_reg <= sel_post;
          drain_cnt <= held_acc;
        end
      end
    end
  end
endmodule

// File: tb/tb_survivor_exchange.sv
// tb_survivor_exchange: directed/random bench for survivor_exchange against a traceback reference model
module tb_survivor_exchange;
  import viterbi_pkg::*;
  localparam int DEPTH = 16;
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, flush = 1'b0;
  logic [11:0] path0 = '0;
  logic [3:0] acs = '0;
  logic [1:0] best_state = '0;
  logic in_ready, out_valid, busy;
  logic [2:0] out_sym;
  survivor_exchange #(.DEPTH(DEPTH), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .path0(path0),
    .acs(acs), .best_state(best_state), .flush(flush), .out_valid(out_valid),
    .out_sym(out_sym), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [11:0] p; logic [3:0] a;} ent_t;
  ent_t hist[$];
  int drain_q[$];
  int n_vec = 0, n_err = 0;
  int pt[4][2] = '{'{0, 2}, '{2, 0}, '{1, 3}, '{3, 1}};
  // survivor entry k of state st0: follow decisions back k inputs, take that input's symbol
  function automatic int trace(int st0, int k);
    int st;
    ent_t e;
    logic [11:0] p;
    st = st0;
    if (k >= hist.size()) return 0;
    for (int j = 0; j < k; j++) begin
      e = hist[hist.size()-1-j];
      st = pt[st][e.a[st]];
    end
    e = hist[hist.size()-1-k];
    p = e.p;
    return int'(p[11-3*st -: 3]);
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(bit v, logic [11:0] p, logic [3:0] a, logic [1:0] b, bit f);
    int sel, es;
    bit ev;
    ent_t e;
    in_valid = v; path0 = p; acs = a; best_state = b; flush = f;
`ifdef SURV_BEST_STATE_EN
    sel = int'(b);
`else
    sel = 0;
`endif
    ev = 0; es = 0;
    chk("in_ready", in_ready, drain_q.size() == 0);
    chk("busy", busy, drain_q.size() != 0);
    if (drain_q.size() != 0) begin
      ev = 1;
      es = drain_q.pop_front();
      if (drain_q.size() == 0) hist.delete();
    end else begin
      if (v) begin
        if (hist.size() == DEPTH) begin
          ev = 1;
          es = trace(sel, DEPTH-1);
        end
        e.p = p; e.a = a;
        hist.push_back(e);
        if (hist.size() > DEPTH) void'(hist.pop_front());
      end
      if (f && hist.size() != 0)
        for (int k = hist.size()-1; k >= 0; k--) drain_q.push_back(trace(sel, k));
    end
    @(posedge clk); #1;
    chk("out_valid", out_valid, ev);
    if (ev) chk("out_sym", out_sym, es);
  endtask
  task automatic do_reset(int n);
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_sym", out_sym, 0);
    hist.delete();
    drain_q.delete();
    reset = 1'b1;
  endtask
  task automatic fill(int n);
    for (int i = 0; i < n; i++) step(1, 12'($urandom), 4'($urandom), 2'($urandom), 0);
  endtask
  initial begin
    int acc;
    do_reset(2);
    step(0, 12'o1234, 4'h0, 2'd0, 1);
    for (int i = 1; i <= 17; i++) step(1, {3'(i), 3'(i+1), 3'(i+2), 3'(i+3)}, 4'h0, 2'd0, 0);
    chk("first_sym", out_sym, 3'd1);
    do_reset(2);
    acc = 0;
    while (acc < 300) begin
      bit v;
      v = $urandom_range(0, 3) != 0;
      step(v, 12'($urandom), acc[0] ? 4'hF : 4'h0, 2'($urandom), 0);
      if (v) acc++;
    end
    for (int i = 0; i < 100; i++) step($urandom_range(0, 4) != 0, 12'($urandom), 4'($urandom), 2'($urandom), 0);
    do_reset(2);
    fill(5);
    step(0, 12'($urandom), 4'($urandom), 2'($urandom), 1);
    for (int i = 0; i < 7; i++) step(0, 12'($urandom), 4'($urandom), 2'($urandom), 1);
    do_reset(2);
    fill(20);
    step(1, 12'($urandom), 4'($urandom), 2'($urandom), 1);
    for (int i = 0; i < 16; i++) step(1, 12'($urandom), 4'($urandom), 2'($urandom), 0);
    step(0, 12'($urandom), 4'($urandom), 2'($urandom), 0);
    fill(18);
    step(0, 12'($urandom), 4'($urandom), 2'($urandom), 0);
    do_reset(2);
    fill(10);
    step(0, 12'($urandom), 4'($urandom), 2'($urandom), 1);
    step(0, 12'($urandom), 4'($urandom), 2'($urandom), 0);
    step(0, 12'($urandom), 4'($urandom), 2'($urandom), 0);
    do_reset(1);
    fill(17);
    step(1, 12'($urandom), 4'($urandom), 2'($urandom), 1);
    for (int i = 0; i < 18; i++) step(0, 12'($urandom), 4'($urandom), 2'($urandom), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
